// File: rtl/cube_scan_controller.sv
`default_nettype none
// cube_scan_controller: blank/load/show scan scheduler for the multi-frame LED cube.
// Rev 1.0 - layer sequencing, per-frame scan repeat and run-time frame wrap.
module cube_scan_controller #(
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 4,
   parameter int FRAME_REPEAT = 50,
   parameter int FRAME_W      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [FRAME_W-1:0] num_frames,
   output logic               ll_start,
   input  logic               ll_done,
   input  logic [2:0]         ll_latch_i,
   output logic [FRAME_W+5:0] mem_addr,
   output logic [7:0]         layer_en,
   output logic [FRAME_W-1:0] frame_idx,
   output logic [2:0]         layer_idx,
   output logic               frame_wrap,
   output logic               busy
);

   localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int SCAN_W  = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(FRAME_REPEAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_LOAD  = 2'd2,
      S_SHOW  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;
   logic [BLANK_W-1:0] blank_cnt, blank_cnt_nxt;
   logic [SCAN_W-1:0]  scan_cnt, scan_cnt_nxt;
   logic               ll_start_nxt;
   logic [7:0]         layer_en_nxt;
   logic [FRAME_W-1:0] frame_idx_nxt;
   logic [2:0]         layer_idx_nxt;
   logic               frame_wrap_nxt;

   // A stored frame count of zero still displays one frame.
   logic [FRAME_W:0]   frames_eff;
   logic [FRAME_W:0]   frame_next;

   assign frames_eff = (num_frames == '0) ? (FRAME_W + 1)'(1) : {1'b0, num_frames};
   assign frame_next = {1'b0, frame_idx} + (FRAME_W + 1)'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         dwell_cnt  <= '0;
         blank_cnt  <= '0;
         scan_cnt   <= '0;
         ll_start   <= 1'b0;
         layer_en   <= '0;
         frame_idx  <= '0;
         layer_idx  <= '0;
         frame_wrap <= 1'b0;
      end else begin
         state      <= state_nxt;
         dwell_cnt  <= dwell_cnt_nxt;
         blank_cnt  <= blank_cnt_nxt;
         scan_cnt   <= scan_cnt_nxt;
         ll_start   <= ll_start_nxt;
         layer_en   <= layer_en_nxt;
         frame_idx  <= frame_idx_nxt;
         layer_idx  <= layer_idx_nxt;
         frame_wrap <= frame_wrap_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      dwell_cnt_nxt  = dwell_cnt;
      blank_cnt_nxt  = blank_cnt;
      scan_cnt_nxt   = scan_cnt;
      ll_start_nxt   = 1'b0;
      layer_en_nxt   = layer_en;
      frame_idx_nxt  = frame_idx;
      layer_idx_nxt  = layer_idx;
      frame_wrap_nxt = 1'b0;

      case (state)
         S_IDLE: begin
            layer_en_nxt = '0;
            if (enable) begin
               state_nxt     = S_BLANK;
               blank_cnt_nxt = '0;
            end
         end

         S_BLANK: begin
            layer_en_nxt = '0;
            if (blank_cnt == BLANK_LAST) begin
               state_nxt     = S_LOAD;
               blank_cnt_nxt = '0;
               ll_start_nxt  = 1'b1;
            end else begin
               blank_cnt_nxt = blank_cnt + BLANK_W'(1);
            end
         end

         S_LOAD: begin
            layer_en_nxt = '0;
            if (ll_done) begin
               state_nxt     = S_SHOW;
               dwell_cnt_nxt = '0;
               layer_en_nxt  = 8'd1 << layer_idx;
            end
         end

         S_SHOW: begin
            if (dwell_cnt == DWELL_LAST) begin
               dwell_cnt_nxt = '0;
               layer_en_nxt  = '0;
               layer_idx_nxt = layer_idx + 3'd1;
               if (layer_idx == 3'd7) begin
                  if (scan_cnt == SCAN_LAST) begin
                     scan_cnt_nxt = '0;
                     // >= so a shrunken frame count forces a wrap here.
                     if (frame_next >= frames_eff) begin
                        frame_idx_nxt  = '0;
                        frame_wrap_nxt = 1'b1;
                     end else begin
                        frame_idx_nxt = frame_next[FRAME_W-1:0];
                     end
                  end else begin
                     scan_cnt_nxt = scan_cnt + SCAN_W'(1);
                  end
               end
               state_nxt = enable ? S_BLANK : S_IDLE;
            end else begin
               dwell_cnt_nxt = dwell_cnt + DWELL_W'(1);
            end
         end

         default: begin
            state_nxt    = S_IDLE;
            layer_en_nxt = '0;
         end
      endcase
   end

   assign mem_addr = {frame_idx, layer_idx, ll_latch_i};
   assign busy     = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cube_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// tb_cube_scan_controller: directed + randomized scenarios against a layer/scan/frame reference model.
// Rev 1.0
module tb_cube_scan_controller;

   localparam int DWELL  = 4;
   localparam int BLANK  = 2;
   localparam int REPEAT = 2;
   localparam int FW     = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [FW-1:0] num_frames;
   logic          ll_start;
   logic          ll_done;
   logic [2:0]    ll_latch_i;
   logic [FW+5:0] mem_addr;
   logic [7:0]    layer_en;
   logic [FW-1:0] frame_idx;
   logic [2:0]    layer_idx;
   logic          frame_wrap;
   logic          busy;

   int compared   = 0;
   int mismatched = 0;

   // Reference position of the scan: layer, completed scans of this frame, frame.
   int exp_layer = 0;
   int exp_scan  = 0;
   int exp_frame = 0;

   cube_scan_controller #(
      .DWELL_CYCLES (DWELL),
      .BLANK_CYCLES (BLANK),
      .FRAME_REPEAT (REPEAT),
      .FRAME_W      (FW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .num_frames (num_frames),
      .ll_start   (ll_start),
      .ll_done    (ll_done),
      .ll_latch_i (ll_latch_i),
      .mem_addr   (mem_addr),
      .layer_en   (layer_en),
      .frame_idx  (frame_idx),
      .layer_idx  (layer_idx),
      .frame_wrap (frame_wrap),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One layer finished: step layer, count scans, advance/wrap frame.
   task automatic model_advance(output bit wrap);
      int nf;
      wrap = 1'b0;
      exp_layer = (exp_layer + 1) % 8;
      if (exp_layer == 0) begin
         exp_scan++;
         if (exp_scan == REPEAT) begin
            exp_scan = 0;
            nf = (num_frames == '0) ? 1 : int'(num_frames);
            if (exp_frame + 1 >= nf) begin
               exp_frame = 0;
               wrap      = 1'b1;
            end else begin
               exp_frame++;
            end
         end
      end
   endtask

   task automatic model_reset();
      exp_layer = 0;
      exp_scan  = 0;
      exp_frame = 0;
   endtask

   // Entered from the first BLANK cycle. d = cycles from ll_start to ll_done;
   // enable drops at dwell cycle drop_at (drop_at >= DWELL keeps it high).
   task automatic do_layer(input int d, input int drop_at);
      bit            wrap;
      bit            en_end;
      logic [FW+5:0] addr_exp;
      en_end = (drop_at >= DWELL);
      for (int i = 0; i < BLANK; i++) begin
         ll_done = 1'($urandom_range(0, 1));
         chk("blank_layer_en", 32'(layer_en), 32'(0));
         chk("blank_ll_start", 32'(ll_start), 32'(0));
         chk("blank_busy", 32'(busy), 32'(1));
         if (i > 0) chk("blank_frame_wrap", 32'(frame_wrap), 32'(0));
         tick();
      end
      for (int k = 0; k <= d; k++) begin
         ll_latch_i = 3'(k);
         ll_done    = (k == d);
         enable     = 1'($urandom_range(0, 1));
         #1;
         addr_exp = {FW'(exp_frame), 3'(exp_layer), 3'(k)};
         chk("load_mem_addr", 32'(mem_addr), 32'(addr_exp));
         chk("load_ll_start", 32'(ll_start), 32'(k == 0));
         chk("load_layer_en", 32'(layer_en), 32'(0));
         tick();
      end
      for (int i = 0; i < DWELL; i++) begin
         enable  = (i < drop_at);
         ll_done = 1'($urandom_range(0, 1));
         chk("show_layer_en", 32'(layer_en), 32'(1) << exp_layer);
         chk("show_layer_idx", 32'(layer_idx), 32'(exp_layer));
         tick();
      end
      ll_done = 1'b0;
      model_advance(wrap);
      chk("end_layer_en", 32'(layer_en), 32'(0));
      chk("end_layer_idx", 32'(layer_idx), 32'(exp_layer));
      chk("end_frame_idx", 32'(frame_idx), 32'(exp_frame));
      chk("end_frame_wrap", 32'(frame_wrap), 32'(wrap));
      chk("end_busy", 32'(busy), 32'(en_end));
   endtask

   task automatic start_from_idle();
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_layer_en", 32'(layer_en), 32'(0));
      enable = 1'b1;
      tick();
   endtask

   task automatic idle_gap(input int n);
      enable = 1'b0;
      for (int i = 0; i < n; i++) begin
         ll_done = 1'($urandom_range(0, 1));
         tick();
         chk("gap_busy", 32'(busy), 32'(0));
         chk("gap_ll_start", 32'(ll_start), 32'(0));
         chk("gap_layer_idx", 32'(layer_idx), 32'(exp_layer));
      end
      ll_done = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      ll_done    = 1'b0;
      ll_latch_i = 3'd0;
      num_frames = FW'(3);
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_ll_start", 32'(ll_start), 32'(0));
      chk("rst_layer_en", 32'(layer_en), 32'(0));
      chk("rst_frame_idx", 32'(frame_idx), 32'(0));
      chk("rst_layer_idx", 32'(layer_idx), 32'(0));
      chk("rst_frame_wrap", 32'(frame_wrap), 32'(0));
      model_reset();

      // First layers, then a full three-frame cycle with a single wrap.
      start_from_idle();
      for (int n = 0; n < 48; n++) do_layer(9, DWELL);

      // Enable dropped mid-dwell of layer 3, then resume at layer 4.
      for (int n = 0; n < 16 && exp_layer != 3; n++) do_layer(9, DWELL);
      do_layer(9, 1);
      chk("drop_layer_idx", 32'(layer_idx), 32'(4));
      idle_gap(5);
      start_from_idle();
      do_layer(9, DWELL);

      // Reset in the middle of a load.
      for (int i = 0; i < BLANK; i++) tick();
      chk("preload_ll_start", 32'(ll_start), 32'(1));
      tick();
      tick();
      rst_n  = 1'b0;
      enable = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_layer_en", 32'(layer_en), 32'(0));
      chk("mid_rst_frame_idx", 32'(frame_idx), 32'(0));
      chk("mid_rst_layer_idx", 32'(layer_idx), 32'(0));
      chk("mid_rst_ll_start", 32'(ll_start), 32'(0));
      chk("mid_rst_frame_wrap", 32'(frame_wrap), 32'(0));
      idle_gap(4);

      // Zero frames behaves as one; then shrink 5 -> 1 while on frame 3.
      num_frames = '0;
      start_from_idle();
      for (int n = 0; n < 40; n++) do_layer($urandom_range(0, 12), DWELL);
      num_frames = FW'(5);
      for (int n = 0; n < 64 && exp_frame != 3; n++) do_layer($urandom_range(0, 12), DWELL);
      chk("reach_frame3", 32'(frame_idx), 32'(3));
      num_frames = FW'(1);
      for (int n = 0; n < 24 && exp_frame != 0; n++) do_layer($urandom_range(0, 12), DWELL);
      chk("shrink_wrapped", 32'(frame_idx), 32'(0));

      // Randomized run: latcher latency, frame count changes, enable drops.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) num_frames = FW'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) begin
            do_layer($urandom_range(0, 12), $urandom_range(0, DWELL - 1));
            idle_gap($urandom_range(1, 4));
            start_from_idle();
         end else begin
            do_layer($urandom_range(0, 12), DWELL);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
